// File: rtl/ucc_seq_ctrl.sv
// Sequencer running 8x8 shift-and-add multiply and 8/8 restoring divide on one add/sub row.
// Define UCC_SEQ_DIV_EN to compile in the divide path and divide-by-zero reporting.
module ucc_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] result_hi,
    output logic [7:0] result_lo,
    output logic       div_by_zero,
    output logic [1:0] row_mode
);

    localparam int unsigned W  = 8;
    localparam int unsigned AW = W + 1;
    localparam int unsigned CW = 3;

    localparam logic [1:0]    RM_PASS = 2'b00;
    localparam logic [1:0]    RM_ADD  = 2'b01;
    localparam logic [1:0]    RM_SUB  = 2'b10;
    localparam logic [CW-1:0] LAST_IT = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q;
    logic [AW-1:0] acc_q;
    logic [W-1:0]  q_q;
    logic [W-1:0]  m_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [W-1:0]  res_hi_q;
    logic [W-1:0]  res_lo_q;
    logic [1:0]    row_mode_q;

    logic          is_div_c;
    logic [AW-1:0] mul_sum_c;
    logic [AW-1:0] step_acc_c;
    logic [W-1:0]  step_q_c;
    logic [1:0]    load_mode_c;
    logic [1:0]    iter_mode_c;

`ifdef UCC_SEQ_DIV_EN
    logic          op_q;
    logic          dbz_q;
    logic [AW-1:0] div_sh_c;
    logic [AW-1:0] div_t_c;

    assign is_div_c    = op_q;
    assign div_by_zero = dbz_q;
`else
    logic unused_op;

    assign unused_op   = op;
    assign is_div_c    = 1'b0;
    assign div_by_zero = 1'b0;
`endif

    // One iteration of the selected algorithm on the current A/Q/M.
    always_comb begin
        mul_sum_c  = {1'b0, acc_q[W-1:0]};
        if (q_q[0]) begin
            mul_sum_c = {1'b0, acc_q[W-1:0]} + {1'b0, m_q};
        end
        step_acc_c = {1'b0, mul_sum_c[AW-1:1]};
        step_q_c   = {mul_sum_c[0], q_q[W-1:1]};
`ifdef UCC_SEQ_DIV_EN
        // A stays below M, so a non-negative difference never reaches bit W.
        div_sh_c = {acc_q[W-1:0], q_q[W-1]};
        div_t_c  = div_sh_c - {1'b0, m_q};
        if (is_div_c) begin
            if (!div_t_c[AW-1]) begin
                step_acc_c = div_t_c;
                step_q_c   = {q_q[W-2:0], 1'b1};
            end else begin
                step_acc_c = div_sh_c;
                step_q_c   = {q_q[W-2:0], 1'b0};
            end
        end
`endif
    end

    // Row mode for the upcoming ITER cycle (registered one cycle ahead).
    always_comb begin
        load_mode_c = q_q[0] ? RM_ADD : RM_PASS;
        iter_mode_c = step_q_c[0] ? RM_ADD : RM_PASS;
        if (is_div_c) begin
            load_mode_c = RM_SUB;
            iter_mode_c = RM_SUB;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            q_q        <= '0;
            m_q        <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            res_hi_q   <= '0;
            res_lo_q   <= '0;
            row_mode_q <= RM_PASS;
`ifdef UCC_SEQ_DIV_EN
            op_q       <= 1'b0;
            dbz_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
`ifdef UCC_SEQ_DIV_EN
                        op_q    <= op;
`endif
                        q_q     <= a;
                        m_q     <= b;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    acc_q <= '0;
                    cnt_q <= '0;
`ifdef UCC_SEQ_DIV_EN
                    dbz_q <= 1'b0;
                    if (op_q && (m_q == '0)) begin
                        dbz_q    <= 1'b1;
                        res_hi_q <= q_q;
                        res_lo_q <= 8'hFF;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else
`endif
                    begin
                        row_mode_q <= load_mode_c;
                        state_q    <= S_ITER;
                    end
                end
                S_ITER: begin
                    acc_q <= step_acc_c;
                    q_q   <= step_q_c;
                    if (cnt_q == LAST_IT) begin
                        res_hi_q   <= step_acc_c[W-1:0];
                        res_lo_q   <= step_q_c;
                        row_mode_q <= RM_PASS;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        cnt_q      <= cnt_q + CW'(1);
                        row_mode_q <= iter_mode_c;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;
    assign row_mode  = row_mode_q;

endmodule

// File: tb/tb_ucc_seq_ctrl.sv
// Scoreboard bench for ucc_seq_ctrl; expectations follow UCC_SEQ_DIV_EN when divides are issued.
module tb_ucc_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result_hi;
    logic [7:0] result_lo;
    logic       div_by_zero;
    logic [1:0] row_mode;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       dbz;
        int         start_cyc;
        int         lat;
        int         adds;
        int         subs;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   busy_cnt;
    int   add_cnt;
    int   sub_cnt;
    int   e0;

    ucc_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result_hi   (result_hi),
        .result_lo   (result_lo),
        .div_by_zero (div_by_zero),
        .row_mode    (row_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, expv, expv, cyc);
        end
    endtask

    // Monitor: pops the oldest expectation on every done pulse.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
            add_cnt  = 0;
            sub_cnt  = 0;
        end else begin
            if (busy) busy_cnt++;
            if (row_mode == 2'b01) add_cnt++;
            if (row_mode == 2'b10) sub_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("result_hi", int'(result_hi), int'(e.hi));
                    chk("result_lo", int'(result_lo), int'(e.lo));
                    chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
                    chk("done_latency", cyc - e.start_cyc, e.lat);
                    chk("busy_cycles", busy_cnt, e.lat);
                    chk("add_cycles", add_cnt, e.adds);
                    chk("sub_cycles", sub_cnt, e.subs);
                end
                busy_cnt = 0;
                add_cnt  = 0;
                sub_cnt  = 0;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) break;
        end
        chk("pending_results", sb.size(), 0);
    endtask

    task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] ehi, input logic [7:0] elo, input logic edbz,
                         input int lat, input int adds, input int subs);
        exp_t t;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start       = 1'b0;
        t.hi        = ehi;
        t.lo        = elo;
        t.dbz       = edbz;
        t.start_cyc = cyc;
        t.lat       = lat;
        t.adds      = adds;
        t.subs      = subs;
        sb.push_back(t);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t t;
        cyc   = 0;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result_hi", int'(result_hi), 0);
        chk("rst_result_lo", int'(result_lo), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        chk("rst_row_mode", int'(row_mode), 0);
        rst = 1'b0;

        issue(1'b0, 8'd13, 8'd11, 8'h00, 8'h8F, 1'b0, 9, 3, 0);
        issue(1'b0, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0, 9, 8, 0);
`ifdef UCC_SEQ_DIV_EN
        issue(1'b1, 8'd200, 8'd7, 8'h04, 8'h1C, 1'b0, 9, 0, 8);
        issue(1'b1, 8'd5, 8'd9, 8'h05, 8'h00, 1'b0, 9, 0, 8);
        issue(1'b1, 8'h55, 8'd0, 8'h55, 8'hFF, 1'b1, 1, 0, 0);
`else
        issue(1'b1, 8'd200, 8'd7, 8'h05, 8'h78, 1'b0, 9, 3, 0);
        issue(1'b1, 8'd5, 8'd9, 8'h00, 8'h2D, 1'b0, 9, 2, 0);
        issue(1'b1, 8'h55, 8'd0, 8'h00, 8'h00, 1'b0, 9, 4, 0);
`endif

        // start pulses in an ITER cycle and in the DONE cycle are dropped
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 8'd13;
        b     = 8'd11;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0    = cyc;
        t     = '{8'h00, 8'h8F, 1'b0, e0, 9, 3, 0};
        sb.push_back(t);
        a = 8'd2;
        b = 8'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (15) @(negedge clk);
        chk("no_second_busy", int'(busy), 0);
        chk("held_result_lo", int'(result_lo), 8'h8F);

        // start held from DONE through the following IDLE cycle launches the next op
        @(negedge clk);
        start = 1'b1;
        a     = 8'd1;
        b     = 8'd200;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0    = cyc;
        t     = '{8'h00, 8'hC8, 1'b0, e0, 9, 1, 0};
        sb.push_back(t);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'd6;
        b     = 8'd7;
        t     = '{8'h00, 8'h2A, 1'b0, e0 + 11, 9, 2, 0};
        sb.push_back(t);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // asynchronous reset in the middle of an ITER sequence
        @(negedge clk);
        start = 1'b1;
        a     = 8'd255;
        b     = 8'd255;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("busy_before_rst", int'(busy), 1);
        chk("row_mode_before_rst", int'(row_mode), 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_result_hi", int'(result_hi), 0);
        chk("midrst_result_lo", int'(result_lo), 0);
        chk("midrst_dbz", int'(div_by_zero), 0);
        chk("midrst_row_mode", int'(row_mode), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 8'd3, 8'd4, 8'h00, 8'h0C, 1'b0, 9, 2, 0);

        repeat (5) @(negedge clk);
        chk("final_queue_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ucc_seq_ctrl.md
# ucc_seq_ctrl

Sequencing controller that time-multiplexes one 8-bit add/subtract cell row to run multi-cycle unsigned 8x8 multiply (shift-and-add) and 8/8 divide (restoring). It sits between a requesting unit and the 8-bit cellular arithmetic row. It owns the operand registers, the iteration counter and the row mode, and returns a 16-bit result through a start/done handshake.

## Interface
- No parameters; the width is fixed at 8 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = multiply, 1 = divide; sampled with `start`.
- `a`  in  8  multiplicand or dividend; sampled with `start`.
- `b`  in  8  multiplier or divisor; sampled with `start`.
- `busy`  out  1  high in LOAD and ITER.
- `done`  out  1  one-cycle pulse; results are valid from this cycle.
- `result_hi`  out  8  product[15:8] or remainder.
- `result_lo`  out  8  product[7:0] or quotient.
- `div_by_zero`  out  1  set when a divide is started with `b`=0.
- `row_mode`  out  2  row mode being driven: 00 pass, 01 add, 10 subtract, 11 unused.

## Operation
- **States:** IDLE, LOAD, ITER, DONE.
- **IDLE:** if `start`=1 on an edge, latch `op`, `a`, `b` and go to LOAD. Otherwise stay in IDLE.
- **LOAD:**
  - Set A=0 (9 bits), Q=`a`, M=`b`, counter=0, and clear `div_by_zero`.
  - If `op`=1 and `b`=0: set `div_by_zero`=1, `result_hi`=`a`, `result_lo`=8'hFF, and go to DONE.
  - Otherwise go to ITER.
- **ITER, multiply (8 iterations):**
  - If Q[0]=1, `row_mode`=01 and {C,A[7:0]} = A[7:0] + M. Otherwise `row_mode`=00 and C=0.
  - Shift {C,A[7:0],Q} right by one.
- **ITER, divide (8 iterations):**
  - Shift {A,Q} left by one.
  - `row_mode`=10; compute T = A − {0,M} at 9-bit width.
  - If T is non-negative: A=T and Q[0]=1. Otherwise A is unchanged and Q[0]=0.
- **ITER exit:** the counter increments every ITER cycle. Leave ITER for DONE after the iteration with counter=7; the counter does not wrap.
- **DONE:**
  - `done`=1 for this cycle.
  - Multiply: `result_hi`=A[7:0], `result_lo`=Q. Divide: `result_hi`=A[7:0] (remainder), `result_lo`=Q (quotient).
  - Next state is IDLE unconditionally.
- **Result hold:** results and `div_by_zero` hold their value until the LOAD of the next operation.
- **`start` outside IDLE:** ignored, including in DONE; it is not queued. In IDLE, `start` is level-sampled, so holding it high starts back-to-back operations.
- **`row_mode`:** 00 in every state except ITER.

## Timing
- **Reset:** `rst`=1 forces IDLE, counter=0, `busy`=0, `done`=0, `result_hi`=0, `result_lo`=0, `div_by_zero`=0, `row_mode`=00, and clears A, Q and M. This holds when asserted mid-operation; no partial result is retained.
- **Normal latency:** with `start` sampled at edge 0:
  - LOAD occupies cycle 1.
  - ITER occupies cycles 2–9.
  - DONE occupies cycle 10 (`done`=1).
  - IDLE from cycle 11. The earliest next start is sampled at edge 11.
- **Divide-by-zero latency:** LOAD in cycle 1, DONE in cycle 2.
- **`busy`:** Moore output, high exactly during LOAD and ITER (9 cycles normally, 1 cycle for divide-by-zero).
- **`done`:** Moore output from the DONE state.
- **Registered outputs:** results and `div_by_zero` are registered.

## Configuration
- `UCC_SEQ_DIV_EN` defined: the divide path, `op`=1 handling and `div_by_zero` logic are compiled in as described above.
- `UCC_SEQ_DIV_EN` undefined:
  - `op` is ignored and every request is a multiply.
  - `div_by_zero` is tied to 0.
  - `row_mode` never takes the value 10.
  - Latency is unchanged.

## Test plan
- **Multiply 13×11:** `op`=0, `a`=13, `b`=11, one-cycle `start` → `done` at cycle 10 with `result_hi`=8'h00, `result_lo`=8'h8F; `busy` high in cycles 1–9.
- **Multiply 255×255:** → `result_hi`=8'hFE, `result_lo`=8'h01; `row_mode` is 01 in all 8 ITER cycles.
- **Divide 200/7:** `op`=1 → `result_lo`=8'h1C, `result_hi`=8'h04, `div_by_zero`=0. Repeat with 5/9 → quotient 0, remainder 5.
- **Divide by zero:** `op`=1, `a`=8'h55, `b`=0 → `done` at cycle 2, `div_by_zero`=1, `result_hi`=8'h55, `result_lo`=8'hFF.
- **Start while busy:** pulse `start` with new operands in cycles 4 and 10 → the first result is unchanged and no second `done` occurs. Holding `start` high through cycle 11 starts the next operation, with `done` at cycle 21.
- **Reset mid-operation:** assert `rst` in cycle 5 → all outputs go to 0 immediately and the state is IDLE. A new 3×4 request then returns 8'h00/8'h0C.
